// File: rtl/led_sequencer_pkg.sv
// led_sequencer_pkg: shared mode, cfg_sel and FSM state encodings for the LED sequencer
package led_sequencer_pkg;
  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_ROTL   = 2'd2,
    MODE_ROTR   = 2'd3
  } mode_e;
  typedef enum logic [1:0] {
    SEL_PATTERN = 2'd0,
    SEL_MODE    = 2'd1,
    SEL_PS_LO   = 2'd2,
    SEL_PS_HI   = 2'd3
  } cfg_sel_e;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_EMIT = 2'd2
  } state_e;
endpackage

// File: rtl/led_prescaler.sv
// led_prescaler: step prescale counter with terminal-count compare
//   clk, rst_n  : clock, async active-low reset
//   clr         : clear the counter (wins over counting)
//   en          : count enable (sequencer in RUN)
//   prescale    : terminal value, compared live so changes apply on the next compare
//   tc          : terminal count, only while enabled
module led_prescaler #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] prescale,
  output logic         tc
);
  logic [W-1:0] cnt;
  // a counter already above a newly lowered prescale simply wraps through zero
  assign tc = en && (cnt == prescale);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clr || tc) ? '0 : en ? cnt + W'(1) : cnt;
endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: steps an 8-bit LED pattern and writes it to the LED register
//   clk, rst_n           : clock, async active-low reset
//   cfg_data/write/sel   : config write (0 pattern, 1 mode, 2 prescale lo, 3 prescale hi)
//   led_data/write/addr  : LED register write port, strobed for one cycle per EMIT
//   busy                 : high in RUN or EMIT
//   LED_SEQ_BOUNCE_EN    : when defined, mode 3 bounces between bit 0 and bit 7
//                          instead of rotating right
module led_sequencer
  import led_sequencer_pkg::*;
#(
  parameter int PRESCALE_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cfg_data,
  input  logic       cfg_write,
  input  logic [1:0] cfg_sel,
  output logic [7:0] led_data,
  output logic       led_write,
  output logic       led_addr,
  output logic       busy
);
  state_e state, state_nx;
  mode_e mode;
  cfg_sel_e sel;
  logic [7:0] base, cur, cur_step;
  logic [PRESCALE_W-1:0] prescale;
  logic [15:0] ps16, ps_new;
  logic load, run, emit, tc;
`ifdef LED_SEQ_BOUNCE_EN
  logic dir, dir_nx;
`endif
  assign sel = cfg_sel_e'(cfg_sel);
  assign load = cfg_write && (sel == SEL_PATTERN || sel == SEL_MODE);
  assign run = state == ST_RUN;
  assign emit = state == ST_EMIT;
  // prescale bytes are merged in a 16-bit view, bits beyond PRESCALE_W drop out on the cast
  assign ps16 = 16'(prescale);
  assign ps_new = (sel == SEL_PS_HI) ? {cfg_data, ps16[7:0]} : {ps16[15:8], cfg_data};
  led_prescaler #(.W(PRESCALE_W)) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (load),
    .en       (run),
    .prescale (prescale),
    .tc       (tc)
  );
  // a pattern/mode write overrides any pending step or EMIT
  always_comb
    state_nx = load ? ST_EMIT
             : emit ? (mode == MODE_STATIC ? ST_IDLE : ST_RUN)
             : (run && tc) ? ST_EMIT : state;
  always_comb begin
`ifdef LED_SEQ_BOUNCE_EN
    // dir=1 means moving left; turn around once the edge bit is reached
    dir_nx = dir ? !cur[7] : cur[0];
`endif
    cur_step = cur;
    case (mode)
      MODE_BLINK: cur_step = (cur == base) ? 8'h00 : base;
      MODE_ROTL:  cur_step = {cur[6:0], cur[7]};
`ifdef LED_SEQ_BOUNCE_EN
      MODE_ROTR:  cur_step = dir_nx ? {cur[6:0], 1'b0} : {1'b0, cur[7:1]};
`else
      MODE_ROTR:  cur_step = {cur[0], cur[7:1]};
`endif
      default:    cur_step = cur;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= ST_IDLE;
      mode     <= MODE_STATIC;
      base     <= 8'h00;
      cur      <= 8'h00;
      prescale <= '0;
`ifdef LED_SEQ_BOUNCE_EN
      dir      <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (cfg_write && sel == SEL_PATTERN) begin
        base <= cfg_data;
        cur  <= cfg_data;
`ifdef LED_SEQ_BOUNCE_EN
        dir  <= 1'b0;
`endif
      end else if (cfg_write && sel == SEL_MODE) begin
        mode <= mode_e'(cfg_data[1:0]);
        cur  <= base;
`ifdef LED_SEQ_BOUNCE_EN
        dir  <= 1'b0;
`endif
      end else if (run && tc) begin
        cur <= cur_step;
`ifdef LED_SEQ_BOUNCE_EN
        dir <= dir_nx;
`endif
      end
      if (cfg_write && (sel == SEL_PS_LO || sel == SEL_PS_HI)) prescale <= PRESCALE_W'(ps_new);
    end
  // outputs decode the state directly so an async reset drops the strobe at once
  assign led_write = emit;
  assign led_addr  = emit;
  assign led_data  = emit ? cur : 8'h00;
  assign busy      = state != ST_IDLE;
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed vectors, corner sequences and randomized model check of led_sequencer
module tb_led_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, cfg_write = 1'b0;
  logic [1:0] cfg_sel = 2'd0;
  logic [7:0] cfg_data = 8'h00;
  logic [7:0] led_data;
  logic led_write, led_addr, busy;
  int n_pass = 0, n_tot = 0;
`ifdef LED_SEQ_BOUNCE_EN
  localparam int B2 = 8'h02, B3 = 8'h04;
`else
  localparam int B2 = 8'h80, B3 = 8'h40;
`endif
  led_sequencer #(.PRESCALE_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_data  (cfg_data),
    .cfg_write (cfg_write),
    .cfg_sel   (cfg_sel),
    .led_data  (led_data),
    .led_write (led_write),
    .led_addr  (led_addr),
    .busy      (busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit w;
    int s;
    int d;
    bit ew;
    int ed;
    bit eb;
  } vec_t;
  vec_t tbl[14];
  bit m_emit, m_run, m_on, m_dir;
  int m_cnt, m_ps, m_mode, m_base, m_cur;
  function automatic int outs();
    return int'({busy, led_write, led_addr, led_data});
  endfunction
  function automatic int exp_o(bit b, bit w, int d);
    return (int'(b) << 10) | (int'(w) << 9) | (int'(w) << 8) | (w ? d : 0);
  endfunction
  task automatic chk(string name, int act, int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask
  task automatic drive(bit w, int s, int d);
    cfg_write = w;
    cfg_sel = 2'(s);
    cfg_data = 8'(d);
    @(posedge clk);
    #1;
    cfg_write = 1'b0;
  endtask
  task automatic wait_write(int exp_d, int exp_gap, string name);
    int g;
    g = 0;
    do begin
      drive(0, 0, 0);
      g++;
    end while (!led_write && g < 40);
    chk({name, " gap"}, g, exp_gap);
    chk({name, " data"}, int'(led_data), exp_d);
  endtask
  task automatic model_reset();
    m_emit = 0; m_run = 0; m_on = 1; m_dir = 0;
    m_cnt = 0; m_ps = 0; m_mode = 0; m_base = 0; m_cur = 0;
  endtask
  task automatic model_step();
    case (m_mode)
      1: begin
        m_on = !m_on;
        m_cur = m_on ? m_base : 0;
      end
      2: m_cur = (m_cur * 2) % 256 + m_cur / 128;
`ifdef LED_SEQ_BOUNCE_EN
      3: begin
        if (!m_dir && m_cur % 2 == 1) m_dir = 1;
        else if (m_dir && m_cur >= 128) m_dir = 0;
        m_cur = m_dir ? (m_cur * 2) % 256 : m_cur / 2;
      end
`else
      3: m_cur = m_cur / 2 + (m_cur % 2) * 128;
`endif
      default: ;
    endcase
  endtask
  task automatic model_edge(bit w, int s, int d);
    if (w && s < 2) begin
      if (s == 0) begin
        m_base = d;
        m_cur = d;
      end else begin
        m_mode = d % 4;
        m_cur = m_base;
      end
      m_on = 1; m_dir = 0; m_cnt = 0; m_emit = 1; m_run = 0;
    end else if (m_emit) begin
      m_emit = 0;
      m_run = m_mode != 0;
    end else if (m_run) begin
      if (m_cnt == m_ps) begin
        model_step();
        m_cnt = 0; m_emit = 1; m_run = 0;
      end else m_cnt = (m_cnt + 1) % 16;
    end
    if (w && s == 2) m_ps = d % 16;
  endtask
  initial begin
    int seq[7];
    seq = '{8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81, 8'h03};
    tbl[0]  = '{1'b1, 0, 8'hA5, 1'b1, 8'hA5, 1'b1};
    tbl[1]  = '{1'b0, 0, 0,     1'b0, 0,     1'b0};
    tbl[2]  = '{1'b0, 0, 0,     1'b0, 0,     1'b0};
    tbl[3]  = '{1'b1, 2, 8'h00, 1'b0, 0,     1'b0};
    tbl[4]  = '{1'b1, 1, 8'h01, 1'b1, 8'hA5, 1'b1};
    tbl[5]  = '{1'b1, 0, 8'h3C, 1'b1, 8'h3C, 1'b1};
    tbl[6]  = '{1'b0, 0, 0,     1'b0, 0,     1'b1};
    tbl[7]  = '{1'b0, 0, 0,     1'b1, 8'h00, 1'b1};
    tbl[8]  = '{1'b0, 0, 0,     1'b0, 0,     1'b1};
    tbl[9]  = '{1'b0, 0, 0,     1'b1, 8'h3C, 1'b1};
    tbl[10] = '{1'b0, 0, 0,     1'b0, 0,     1'b1};
    tbl[11] = '{1'b0, 0, 0,     1'b1, 8'h00, 1'b1};
    tbl[12] = '{1'b1, 1, 8'h00, 1'b1, 8'h3C, 1'b1};
    tbl[13] = '{1'b0, 0, 0,     1'b0, 0,     1'b0};
    @(posedge clk);
    #1;
    chk("reset outputs", outs(), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].w, tbl[i].s, tbl[i].d);
      chk($sformatf("vec%0d", i), outs(), exp_o(tbl[i].eb, tbl[i].ew, tbl[i].ed));
    end
    drive(1, 2, 3);
    drive(1, 1, 2);
    chk("mode write emit", outs(), exp_o(1, 1, 8'h3C));
    drive(1, 0, 8'h81);
    chk("rotl load emit", outs(), exp_o(1, 1, 8'h81));
    wait_write(8'h03, 5, "rotl0");
    drive(1, 3, 8'hFF);
    wait_write(8'h06, 4, "rotl hi ignored");
    for (int i = 0; i < 7; i++) wait_write(seq[i], 5, $sformatf("rotl%0d", i + 2));
    repeat (4) drive(0, 0, 0);
    chk("run before collide", outs(), exp_o(1, 0, 0));
    drive(1, 0, 8'h5A);
    chk("collide emit", outs(), exp_o(1, 1, 8'h5A));
    wait_write(8'hB4, 5, "after collide");
    drive(1, 2, 0);
    drive(1, 1, 3);
    drive(1, 0, 8'h02);
    chk("mode3 load", outs(), exp_o(1, 1, 8'h02));
    wait_write(8'h01, 2, "mode3 s1");
    wait_write(B2, 2, "mode3 s2");
    wait_write(B3, 2, "mode3 s3");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset in emit", outs(), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, 0, 0);
    chk("idle after release", outs(), 0);
    drive(1, 0, 8'h11);
    chk("post reset emit", outs(), exp_o(1, 1, 8'h11));
    drive(0, 0, 0);
    chk("post reset static", outs(), 0);
    drive(0, 0, 0);
    chk("post reset quiet", outs(), 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 800; i++) begin
      bit w;
      int s, d;
      w = $urandom_range(0, 4) == 0;
      s = $urandom_range(0, 3);
      d = $urandom_range(0, 255);
      model_edge(w, s, d);
      drive(w, s, d);
      chk($sformatf("random%0d", i), outs(), exp_o(m_emit || m_run, m_emit, m_cur));
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
